// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - double-buffered pixel RAM arbiter with tear-free front/back swap
module framebuffer_arbiter #(
    parameter int ADDR_W        = 11,
    parameter int DATA_W        = 24,
    parameter int HOST_WAIT_MAX = 15
) (
    input  logic              clk_25MHz,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    input  logic              frame_end,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              front_sel,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    localparam logic [7:0] WAIT_MAX = 8'(HOST_WAIT_MAX);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       host_block;
    logic       force_host;

    // Host is frozen out while a swap is pending so the back buffer is stable at the flip.
    always_comb begin
        host_block = (state == S_PENDING);
        force_host = host_req && !host_block && (wait_cnt == WAIT_MAX);
        disp_gnt   = !rst && disp_req && !force_host;
        host_gnt   = !rst && host_req && !host_block && (!disp_req || force_host);
    end

    assign disp_rdata = ram_rdata;

    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            front_sel   <= 1'b0;
            swap_done   <= 1'b0;
            wait_cnt    <= 8'd0;
            disp_rvalid <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            swap_done   <= 1'b0;
            // A read issued to the RAM last cycle returns data this cycle.
            disp_rvalid <= ram_en && !ram_we;

            if (disp_gnt) begin
                ram_en   <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= {front_sel, disp_addr};
            end else if (host_gnt) begin
                ram_en    <= 1'b1;
                ram_we    <= 1'b1;
                ram_addr  <= {~front_sel, host_addr};
                ram_wdata <= host_wdata;
            end else begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
            end

            if (host_block || !host_req || host_gnt) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (swap_req) begin
                        state <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (frame_end) begin
                        front_sel <= ~front_sel;
                        swap_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - directed self-checking bench for framebuffer_arbiter
module tb_framebuffer_arbiter;

    logic        clk_25MHz = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [10:0] disp_addr;
    logic        disp_gnt;
    logic [23:0] disp_rdata;
    logic        disp_rvalid;
    logic        host_req;
    logic [10:0] host_addr;
    logic [23:0] host_wdata;
    logic        host_gnt;
    logic        frame_end;
    logic        swap_req;
    logic        swap_done;
    logic        front_sel;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    framebuffer_arbiter #(.ADDR_W(11), .DATA_W(24), .HOST_WAIT_MAX(15)) dut (
        .clk_25MHz  (clk_25MHz),
        .rst        (rst),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_gnt   (disp_gnt),
        .disp_rdata (disp_rdata),
        .disp_rvalid(disp_rvalid),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .frame_end  (frame_end),
        .swap_req   (swap_req),
        .swap_done  (swap_done),
        .front_sel  (front_sel),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_25MHz);
    endtask

    initial begin
        rst = 1'b1; disp_req = 0; disp_addr = 0; host_req = 0; host_addr = 0;
        host_wdata = 0; frame_end = 0; swap_req = 0; ram_rdata = 0;

        // Reset held: toggle inputs, everything must stay 0
        for (int i = 0; i < 4; i++) begin
            disp_req = i[0]; host_req = ~i[0]; swap_req = i[0]; frame_end = i[0];
            disp_addr = 11'h155 + 11'(i); host_addr = 11'h2AA; host_wdata = 24'hFFFFFF;
            mid();
            check("rst_ram_en", ram_en, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_wdata", ram_wdata, 0);
            check("rst_rvalid", disp_rvalid, 0);
            check("rst_swap_done", swap_done, 0);
            check("rst_front_sel", front_sel, 0);
            check("rst_disp_gnt", disp_gnt, 0);
            check("rst_host_gnt", host_gnt, 0);
            cyc();
        end
        rst = 0; disp_req = 0; host_req = 0; swap_req = 0; frame_end = 0;
        cyc();

        // First display read
        disp_req = 1; disp_addr = 11'h005;
        mid();
        check("rd0_disp_gnt", disp_gnt, 1);
        check("rd0_host_gnt", host_gnt, 0);
        cyc();
        disp_req = 0;
        mid();
        check("rd0_ram_en", ram_en, 1);
        check("rd0_ram_we", ram_we, 0);
        check("rd0_ram_addr", ram_addr, 12'h005);
        check("rd0_rvalid_early", disp_rvalid, 0);
        ram_rdata = 24'h123456;
        cyc();
        mid();
        check("rd0_rvalid", disp_rvalid, 1);
        check("rd0_rdata", disp_rdata, 24'h123456);
        check("rd0_ram_en_off", ram_en, 0);
        cyc();
        mid();
        check("rd0_rvalid_off", disp_rvalid, 0);

        // Host-only write goes to the back buffer
        host_req = 1; host_addr = 11'h010; host_wdata = 24'hABCDEF;
        mid();
        check("wr_host_gnt", host_gnt, 1);
        check("wr_disp_gnt", disp_gnt, 0);
        cyc();
        host_req = 0;
        mid();
        check("wr_ram_en", ram_en, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 12'h810);
        check("wr_ram_wdata", ram_wdata, 24'hABCDEF);
        disp_req = 1; disp_addr = 11'h006;
        cyc();
        disp_req = 0;
        mid();
        check("rd1_wdata_hold", ram_wdata, 24'hABCDEF);
        check("rd1_ram_we", ram_we, 0);
        check("rd1_ram_addr", ram_addr, 12'h006);
        cyc();

        // Starvation: host wins every 16th cycle
        disp_req = 1; disp_addr = 11'h001; host_req = 1; host_addr = 11'h020; host_wdata = 24'h111111;
        for (int i = 0; i < 32; i++) begin
            mid();
            check("starve_host_gnt", host_gnt, (i % 16 == 15) ? 1 : 0);
            check("starve_disp_gnt", disp_gnt, (i % 16 == 15) ? 0 : 1);
            if (i == 16) begin
                check("starve_ram_we", ram_we, 1);
                check("starve_ram_addr", ram_addr, 12'h820);
            end
            cyc();
        end
        disp_req = 0; host_req = 0;
        cyc();

        // Swap: host blocked while pending, flip at frame_end
        host_req = 1; host_addr = 11'h030; host_wdata = 24'h0000AA; swap_req = 1;
        mid();
        check("sw_req_host_gnt", host_gnt, 1);
        cyc();
        swap_req = 0;
        for (int i = 0; i < 100; i++) begin
            mid();
            check("sw_pend_host_gnt", host_gnt, 0);
            cyc();
        end
        frame_end = 1;
        mid();
        check("sw_fe_host_gnt", host_gnt, 0);
        check("sw_fe_front_sel", front_sel, 0);
        check("sw_fe_swap_done", swap_done, 0);
        cyc();
        frame_end = 0;
        mid();
        check("sw_front_sel", front_sel, 1);
        check("sw_swap_done", swap_done, 1);
        check("sw_post_host_gnt", host_gnt, 1);
        cyc();
        host_req = 0;
        mid();
        check("sw_done_pulse", swap_done, 0);
        check("sw_wr_ram_addr", ram_addr, 12'h030);
        check("sw_wr_ram_we", ram_we, 1);
        disp_req = 1; disp_addr = 11'h005;
        cyc();
        disp_req = 0;
        mid();
        check("sw_rd_ram_addr", ram_addr, 12'h805);
        cyc();

        // Reset mid-read with a swap pending
        swap_req = 1;
        cyc();
        swap_req = 0; disp_req = 1; disp_addr = 11'h007;
        mid();
        check("mr_disp_gnt", disp_gnt, 1);
        cyc();
        disp_req = 0; rst = 1;
        #1;
        check("mr_ram_en_async", ram_en, 0);
        check("mr_front_async", front_sel, 0);
        mid();
        check("mr_rvalid_a", disp_rvalid, 0);
        cyc();
        rst = 0;
        mid();
        check("mr_rvalid_b", disp_rvalid, 0);
        check("mr_front_sel", front_sel, 0);
        host_req = 1; host_addr = 11'h040;
        #1;
        check("mr_idle_host_gnt", host_gnt, 1);
        cyc();
        host_req = 0;
        mid();
        check("mr_rvalid_c", disp_rvalid, 0);
        check("mr_wr_ram_addr", ram_addr, 12'h840);
        cyc();

        // Simultaneous swap_req + frame_end does not flip
        swap_req = 1; frame_end = 1;
        cyc();
        swap_req = 0; frame_end = 0; host_req = 1;
        mid();
        check("sim_front_sel", front_sel, 0);
        check("sim_swap_done", swap_done, 0);
        check("sim_pend_host_gnt", host_gnt, 0);
        for (int i = 0; i < 49; i++) cyc();
        frame_end = 1;
        cyc();
        frame_end = 0; host_req = 0;
        mid();
        check("sim2_front_sel", front_sel, 1);
        check("sim2_swap_done", swap_done, 1);
        cyc();
        frame_end = 1;
        cyc();
        frame_end = 0;
        mid();
        check("idle_fe_front_sel", front_sel, 1);
        check("idle_fe_swap_done", swap_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
